// File: rtl/clk_div_gate_pkg.sv
// clk_div_gate_pkg: shared channel configuration type and ratio normalisation.
package clk_div_gate_pkg;

    localparam int MaxDivWidth = 32;

    typedef struct packed {
        logic [MaxDivWidth-1:0] div;
        logic                   en;
    } chan_cfg_t;

    // A ratio of zero behaves as a ratio of one.
    function automatic logic [MaxDivWidth-1:0] norm_div(input logic [MaxDivWidth-1:0] d);
        return (d == '0) ? MaxDivWidth'(1) : d;
    endfunction

endpackage

// File: rtl/clk_div_gate_channel.sv
// clk_div_gate_channel: one divided/gated clock with updates deferred to period boundaries.
module clk_div_gate_channel
    import clk_div_gate_pkg::*;
#(
    parameter int   DIV_WIDTH   = 8,
    parameter int   DEFAULT_DIV = 1,
    parameter logic DEFAULT_EN  = 1'b0
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      test_en,
    input  logic      wr,
    input  chan_cfg_t cfg,
    input  logic      sync,
    output logic      busy,
    output logic      clk_out
);

    localparam logic [DIV_WIDTH-1:0] RstDiv = DIV_WIDTH'((DEFAULT_DIV < 1) ? 1 : DEFAULT_DIV);

    logic [DIV_WIDTH-1:0] cnt_q, div_q, pend_div_q;
    logic                 en_q, pend_q, pend_en_q, boot_q;
    logic                 last, apply, gate_en;

    assign last    = cnt_q == div_q - DIV_WIDTH'(1);
    assign apply   = pend_q & (last | ~en_q);
    assign gate_en = en_q & last;
    assign busy    = pend_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            div_q      <= RstDiv;
            en_q       <= 1'b0;
            pend_q     <= 1'b0;
            pend_div_q <= RstDiv;
            pend_en_q  <= 1'b0;
            boot_q     <= 1'b1;
        end else begin
            boot_q <= 1'b0;
            if (apply) begin
                div_q  <= pend_div_q;
                en_q   <= pend_en_q;
                cnt_q  <= '0;
                pend_q <= 1'b0;
            end else begin
                if (boot_q) en_q <= DEFAULT_EN;
                cnt_q <= (!en_q || last || sync) ? '0 : cnt_q + DIV_WIDTH'(1);
            end
            // A write is only accepted while nothing is pending, so it never races an apply.
            if (wr) begin
                pend_q     <= 1'b1;
                pend_div_q <= DIV_WIDTH'(norm_div(cfg.div));
                pend_en_q  <= cfg.en;
            end
        end
    end

    tc_clk_gating i_gate (
        .clk_i    (clk),
        .en_i     (gate_en),
        .test_en_i(test_en),
        .clk_o    (clk_out)
    );

endmodule

// File: rtl/tc_clk_gating.sv
// tc_clk_gating: latch-based glitch-free clock gate with DFT override.
module tc_clk_gating (
    input  logic clk_i,
    input  logic en_i,
    input  logic test_en_i,
    output logic clk_o
);

    logic en_latch;

    // Enable is captured only while the clock is low so the high phase is never cut.
    always_latch begin
        if (!clk_i) en_latch <= en_i | test_en_i;
    end

    assign clk_o = clk_i & en_latch;

endmodule

// File: rtl/clk_div_gate_multi.sv
// clk_div_gate_multi: bank of independently configurable divided/gated clocks.
module clk_div_gate_multi
    import clk_div_gate_pkg::*;
#(
    parameter int   NUM_CHANNELS = 2,
    parameter int   DIV_WIDTH    = 8,
    parameter int   DEFAULT_DIV  = 1,
    parameter logic DEFAULT_EN   = 1'b0,
    localparam int  ChanWidth    = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    test_en_i,
    input  logic                    cfg_valid_i,
    output logic                    cfg_ready_o,
    input  logic [ChanWidth-1:0]    cfg_chan_i,
    input  logic [DIV_WIDTH-1:0]    cfg_div_i,
    input  logic                    cfg_en_i,
    output logic                    cfg_err_o,
    input  logic                    sync_i,
    output logic [NUM_CHANNELS-1:0] busy_o,
    output logic [NUM_CHANNELS-1:0] clks_o
);

    logic      in_range, err_q;
    chan_cfg_t cfg;

    assign in_range    = int'(cfg_chan_i) < NUM_CHANNELS;
    assign cfg_ready_o = in_range ? ~busy_o[cfg_chan_i] : 1'b1;
    assign cfg.div     = MaxDivWidth'(cfg_div_i);
    assign cfg.en      = cfg_en_i;
    assign cfg_err_o   = err_q;

    // Out-of-range requests are always accepted and dropped, flagged one cycle later.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) err_q <= 1'b0;
        else       err_q <= cfg_valid_i & ~in_range;
    end

    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_chan
        clk_div_gate_channel #(
            .DIV_WIDTH  (DIV_WIDTH),
            .DEFAULT_DIV(DEFAULT_DIV),
            .DEFAULT_EN (DEFAULT_EN)
        ) i_chan (
            .clk    (clk_i),
            .rst    (rst_i),
            .test_en(test_en_i),
            .wr     (cfg_valid_i & cfg_ready_o & in_range & (cfg_chan_i == ChanWidth'(g))),
            .cfg    (cfg),
            .sync   (sync_i),
            .busy   (busy_o[g]),
            .clk_out(clks_o[g])
        );
    end

endmodule

// File: tb/tb_clk_div_gate_multi.sv
// tb_clk_div_gate_multi: scoreboard bench for the divided/gated clock bank.
module tb_clk_div_gate_multi;

    localparam int NC = 3;

    logic          clk = 1'b0;
    logic          rst_i, test_en_i, cfg_valid_i, cfg_en_i, sync_i;
    logic [1:0]    cfg_chan_i;
    logic [7:0]    cfg_div_i;
    logic          cfg_ready_o, cfg_err_o;
    logic [NC-1:0] busy_o, clks_o;

    typedef struct {
        int cyc;
        int ch;
    } exp_t;

    exp_t sb_q[$];
    int   cur, checks, errors;

    always #5 clk = ~clk;

    clk_div_gate_multi #(
        .NUM_CHANNELS(NC),
        .DIV_WIDTH   (8),
        .DEFAULT_DIV (4),
        .DEFAULT_EN  (1'b1)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .test_en_i  (test_en_i),
        .cfg_valid_i(cfg_valid_i),
        .cfg_ready_o(cfg_ready_o),
        .cfg_chan_i (cfg_chan_i),
        .cfg_div_i  (cfg_div_i),
        .cfg_en_i   (cfg_en_i),
        .cfg_err_o  (cfg_err_o),
        .sync_i     (sync_i),
        .busy_o     (busy_o),
        .clks_o     (clks_o)
    );

    task automatic push(input int ch, input int first, input int period, input int n);
        for (int k = 0; k < n; k++) sb_q.push_back('{cyc: first + k * period, ch: ch});
    endtask

    // Ends cycle `cur`; the high phase sampled here is the gated edge closing that cycle.
    task automatic step(input logic [NC-1:0] mask);
        @(posedge clk);
        #1;
        for (int c = 0; c < NC; c++) begin
            if (mask[c]) begin
                logic exp_p;
                exp_p = 1'b0;
                for (int i = 0; i < sb_q.size(); i++) begin
                    if (sb_q[i].cyc == cur && sb_q[i].ch == c) begin
                        exp_p = 1'b1;
                        sb_q.delete(i);
                        break;
                    end
                end
                checks++;
                if (clks_o[c] !== exp_p) begin
                    errors++;
                    $display("FAIL pulse ch%0d cycle %0d: got %b expected %b", c, cur, clks_o[c], exp_p);
                end
            end
        end
        cur++;
    endtask

    task automatic run_to(input int n, input logic [NC-1:0] mask);
        while (cur < n) step(mask);
    endtask

    task automatic write(input int ch, input int div, input logic en);
        cfg_valid_i = 1'b1;
        cfg_chan_i  = 2'(ch);
        cfg_div_i   = 8'(div);
        cfg_en_i    = en;
    endtask

    task automatic test_reset;
        rst_i = 1'b1; test_en_i = 1'b0; cfg_valid_i = 1'b0; cfg_chan_i = '0;
        cfg_div_i = '0; cfg_en_i = 1'b0; sync_i = 1'b0; cur = 0;
        step(3'b111);
        step(3'b111);
        checks++;
        if (busy_o !== 3'b000 || cfg_err_o !== 1'b0 || cfg_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: busy=%b err=%b ready=%b expected busy=000 err=0 ready=1", busy_o, cfg_err_o, cfg_ready_o);
        end
        cur   = 0;
        rst_i = 1'b0;
    endtask

    task automatic test_reset_release;
        push(0, 4, 4, 3);
        run_to(14, 3'b001);
    endtask

    task automatic test_div_change;
        push(0, 16, 3, 3);
        push(1, 16, 6, 2);
        write(0, 3, 1'b1);
        #1;
        checks++;
        if (cfg_ready_o !== 1'b1) begin
            errors++; $display("FAIL ready_ch0_idle: got %b expected 1", cfg_ready_o);
        end
        step(3'b011);
        cfg_valid_i = 1'b0;
        checks++;
        if (busy_o !== 3'b001) begin
            errors++; $display("FAIL busy_after_write: got %b expected 001", busy_o);
        end
        write(0, 7, 1'b1);
        #1;
        checks++;
        if (cfg_ready_o !== 1'b0) begin
            errors++; $display("FAIL ready_ch0_busy: got %b expected 0", cfg_ready_o);
        end
        write(1, 6, 1'b1);
        #1;
        checks++;
        if (cfg_ready_o !== 1'b1) begin
            errors++; $display("FAIL ready_ch1_idle: got %b expected 1", cfg_ready_o);
        end
        step(3'b011);
        cfg_valid_i = 1'b0;
        checks++;
        if (busy_o !== 3'b011) begin
            errors++; $display("FAIL busy_both: got %b expected 011", busy_o);
        end
        step(3'b011);
        checks++;
        if (busy_o !== 3'b000) begin
            errors++; $display("FAIL busy_applied: got %b expected 000", busy_o);
        end
        run_to(23, 3'b011);
    endtask

    task automatic test_cfg_err;
        push(0, 25, 3, 2);
        push(1, 28, 6, 1);
        write(3, 1, 1'b0);
        #1;
        checks++;
        if (cfg_ready_o !== 1'b1) begin
            errors++; $display("FAIL ready_out_of_range: got %b expected 1", cfg_ready_o);
        end
        step(3'b011);
        cfg_valid_i = 1'b0;
        checks++;
        if (cfg_err_o !== 1'b1 || busy_o !== 3'b000) begin
            errors++; $display("FAIL err_pulse: err=%b busy=%b expected err=1 busy=000", cfg_err_o, busy_o);
        end
        step(3'b011);
        checks++;
        if (cfg_err_o !== 1'b0) begin
            errors++; $display("FAIL err_one_cycle: got %b expected 0", cfg_err_o);
        end
        run_to(29, 3'b011);
    endtask

    task automatic test_sync;
        push(0, 31, 4, 2);
        push(0, 42, 4, 6);
        push(1, 34, 6, 1);
        push(1, 44, 6, 4);
        write(0, 4, 1'b1);
        step(3'b011);
        cfg_valid_i = 1'b0;
        run_to(38, 3'b011);
        sync_i = 1'b1;
        step(3'b011);
        sync_i = 1'b0;
        run_to(63, 3'b011);
    endtask

    task automatic test_reset_busy;
        write(1, 2, 1'b1);
        step(3'b011);
        cfg_valid_i = 1'b0;
        checks++;
        if (busy_o !== 3'b010) begin
            errors++; $display("FAIL busy_before_reset: got %b expected 010", busy_o);
        end
        rst_i = 1'b1;
        #1;
        checks++;
        if (busy_o !== 3'b000 || clks_o !== 3'b000) begin
            errors++; $display("FAIL reset_midop: busy=%b clks=%b expected 000 000", busy_o, clks_o);
        end
        step(3'b111);
        step(3'b111);
        test_en_i = 1'b1;
        step(3'b000);
        checks++;
        if (clks_o !== 3'b111) begin
            errors++; $display("FAIL test_en_high: got %b expected 111", clks_o);
        end
        @(negedge clk);
        #1;
        checks++;
        if (clks_o !== 3'b000) begin
            errors++; $display("FAIL test_en_low: got %b expected 000", clks_o);
        end
        test_en_i = 1'b0;
        step(3'b111);
        cur   = 0;
        rst_i = 1'b0;
        push(0, 4, 4, 2);
        push(1, 4, 4, 2);
        run_to(9, 3'b011);
    endtask

    task automatic test_boundaries;
        push(2, 12, 1, 5);
        write(2, 0, 1'b1);
        step(3'b100);
        push(0, 12, 4, 1);
        write(0, 4, 1'b0);
        #1;
        checks++;
        if (cfg_ready_o !== 1'b1) begin
            errors++; $display("FAIL ready_ch0_disable: got %b expected 1", cfg_ready_o);
        end
        step(3'b101);
        cfg_valid_i = 1'b0;
        checks++;
        if (busy_o !== 3'b101) begin
            errors++; $display("FAIL busy_boundary: got %b expected 101", busy_o);
        end
        run_to(17, 3'b101);
        checks++;
        if (busy_o !== 3'b000) begin
            errors++; $display("FAIL busy_final: got %b expected 000", busy_o);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset;
        test_reset_release;
        test_div_change;
        test_cfg_err;
        test_sync;
        test_reset_busy;
        test_boundaries;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: got %0d entries expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
